// File: rtl/alu_operand_seq.sv
// Operand sequencer for a switch-driven ALU: a debounced pushbutton steps through
// loading A, B and the opcode, one execute cycle, then shows the captured result.
module alu_operand_seq #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        key_n,
  input  logic [17:0] sw,
  input  logic [31:0] outport,
  input  logic [2:0]  alu_flags,
  output logic [31:0] portA,
  output logic [31:0] portB,
  output logic [3:0]  aluop,
  output logic        op_valid,
  output logic [31:0] result,
  output logic [2:0]  flags,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_e;

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  state_e      state_q, state_d;
  logic        sync1_q, sync2_q;
  logic        db_level_q, db_level_d;
  logic [15:0] db_cnt_q, db_cnt_d;
  logic        press_q, press_d;
  logic [31:0] porta_q, porta_d;
  logic [31:0] portb_q, portb_d;
  logic [3:0]  aluop_q, aluop_d;
  logic [31:0] result_q, result_d;
  logic [2:0]  flags_q, flags_d;

  logic        load_a, load_b, load_op, capture, exec_active;
  logic [31:0] operand;

  assign operand = {{16{sw[16]}}, sw[15:0]};

  // The press pulse is raised on the same edge the debounced level falls,
  // so the FSM acts one cycle after the level is accepted.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    press_d    = 1'b0;
    if (sync2_q != db_level_q) begin
      if (db_cnt_q == CNT_LAST) begin
        db_level_d = sync2_q;
        press_d    = ~sync2_q;
      end else if (db_cnt_q != '1) begin
        db_cnt_d = db_cnt_q + 16'd1;
      end else begin
        db_cnt_d = db_cnt_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= LOAD_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort (sw[17]) wins over any load; EXEC never looks at the key.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_A:  if (press_q) state_d = sw[17] ? LOAD_A : LOAD_B;
      LOAD_B:  if (press_q) state_d = sw[17] ? LOAD_A : LOAD_OP;
      LOAD_OP: if (press_q) state_d = sw[17] ? LOAD_A : EXEC;
      EXEC:    state_d = SHOW;
      SHOW:    if (press_q) state_d = LOAD_A;
      default: state_d = LOAD_A;
    endcase
  end

  always_comb begin
    load_a      = 1'b0;
    load_b      = 1'b0;
    load_op     = 1'b0;
    capture     = 1'b0;
    exec_active = 1'b0;
    case (state_q)
      LOAD_A:  load_a  = press_q & ~sw[17];
      LOAD_B:  load_b  = press_q & ~sw[17];
      LOAD_OP: load_op = press_q & ~sw[17];
      EXEC: begin
        capture     = 1'b1;
        exec_active = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    porta_d  = load_a  ? operand   : porta_q;
    portb_d  = load_b  ? operand   : portb_q;
    aluop_d  = load_op ? sw[3:0]   : aluop_q;
    result_d = capture ? outport   : result_q;
    flags_d  = capture ? alu_flags : flags_q;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      db_level_q <= 1'b1;
      db_cnt_q   <= '0;
      press_q    <= 1'b0;
      porta_q    <= '0;
      portb_q    <= '0;
      aluop_q    <= '0;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      sync1_q    <= key_n;
      sync2_q    <= sync1_q;
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      press_q    <= press_d;
      porta_q    <= porta_d;
      portb_q    <= portb_d;
      aluop_q    <= aluop_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
    end
  end

  assign portA    = porta_q;
  assign portB    = portb_q;
  assign aluop    = aluop_q;
  assign result   = result_q;
  assign flags    = flags_q;
  assign op_valid = exec_active;
  assign state    = state_q;

endmodule

// File: tb/tb_alu_operand_seq.sv
// Self-checking bench for alu_operand_seq: a simple ALU stub feeds outport, and a
// sequence-level model tracks the expected operands, state and captured result.
module tb_alu_operand_seq;

  localparam int D = 4;

  logic        CLK;
  logic        nRST;
  logic        key_n;
  logic [17:0] sw;
  logic [31:0] outport;
  logic [2:0]  alu_flags;
  logic [31:0] portA, portB, result;
  logic [3:0]  aluop;
  logic        op_valid;
  logic [2:0]  flags, state;

  int total;
  int bad;
  int ov_total;

  int          m_state;
  logic [31:0] m_a, m_b, m_res;
  logic [3:0]  m_op;
  logic [2:0]  m_flags;

  alu_operand_seq #(.DEBOUNCE_CYCLES(D)) dut (
    .CLK(CLK), .nRST(nRST), .key_n(key_n), .sw(sw),
    .outport(outport), .alu_flags(alu_flags),
    .portA(portA), .portB(portB), .aluop(aluop), .op_valid(op_valid),
    .result(result), .flags(flags), .state(state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] alu_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a - b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [2:0] alu_flg(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
    logic [31:0] r;
    logic        ovf;
    r   = alu_res(a, b, op);
    ovf = 1'b0;
    if (op == 4'd2) ovf = (a[31] == b[31]) && (r[31] != a[31]);
    if (op == 4'd3) ovf = (a[31] != b[31]) && (r[31] != a[31]);
    return {ovf, r[31], r == 32'd0};
  endfunction

  assign outport   = alu_res(portA, portB, aluop);
  assign alu_flags = alu_flg(portA, portB, aluop);

  always @(negedge CLK) if (op_valid) ov_total <= ov_total + 1;

  function automatic logic [31:0] sext(input logic [17:0] s);
    return {{16{s[16]}}, s[15:0]};
  endfunction

  task automatic model_reset();
    m_state = 0; m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_flags = '0;
  endtask

  task automatic model_press(input logic [17:0] s);
    if (s[17]) m_state = 0;
    else begin
      case (m_state)
        0: begin m_a = sext(s); m_state = 1; end
        1: begin m_b = sext(s); m_state = 2; end
        2: begin
          m_op    = s[3:0];
          m_res   = alu_res(m_a, m_b, m_op);
          m_flags = alu_flg(m_a, m_b, m_op);
          m_state = 4;
        end
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic do_press(input logic [17:0] s);
    @(negedge CLK);
    sw    = s;
    key_n = 1'b0;
    repeat (D + 6) @(negedge CLK);
    key_n = 1'b1;
    repeat (D + 6) @(negedge CLK);
    model_press(s);
  endtask

  function automatic logic [17:0] rand_sw();
    logic [17:0] s;
    s = 18'($urandom);
    s[17] = 1'b0;
    return s;
  endfunction

  task automatic goto_load_op();
    if (m_state != 0 && m_state != 1 && m_state != 2) do_press(rand_sw());
    while (m_state != 2) do_press(rand_sw());
  endtask

  task automatic test_reset();
    nRST = 1'b0; key_n = 1'b1; sw = '0;
    model_reset();
    #1;
    total++; if (state !== 3'd0) begin bad++; $display("[TB] FAIL reset_state: got %0d want 0", state); end
    total++; if ({portA, portB, aluop, result, flags, op_valid} !== '0) begin
      bad++; $display("[TB] FAIL reset_outputs: A=%h B=%h op=%h res=%h fl=%h v=%b want all 0",
                      portA, portB, aluop, result, flags, op_valid);
    end
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    repeat (D + 4) @(negedge CLK);
    total++; if (state !== 3'd0 || portA !== 32'd0) begin
      bad++; $display("[TB] FAIL reset_idle: state=%0d A=%h want 0/0", state, portA);
    end
  endtask

  task automatic test_clean_sequence();
    int n;
    bit found;
    int ov0;
    found = 0;
    n = 0;
    @(negedge CLK);
    sw    = 18'h00005;
    key_n = 1'b0;
    for (int i = 1; i <= 40 && !found; i++) begin
      @(posedge CLK); #1;
      if (portA === 32'h5) begin found = 1; n = i; end
    end
    total++; if (!found || n != D + 3) begin
      bad++; $display("[TB] FAIL latency: got %0d cycles (found=%0d) want %0d", n, found, D + 3);
    end
    repeat (D + 6) @(negedge CLK);
    key_n = 1'b1;
    repeat (D + 6) @(negedge CLK);
    model_press(18'h00005);
    total++; if (portA !== 32'h00000005 || state !== 3'd1) begin
      bad++; $display("[TB] FAIL clean_A: A=%h state=%0d want 00000005/1", portA, state);
    end
    do_press(18'h1FFFE);
    total++; if (portB !== 32'hFFFFFFFE || state !== 3'd2) begin
      bad++; $display("[TB] FAIL clean_B: B=%h state=%0d want fffffffe/2", portB, state);
    end
    ov0 = ov_total;
    do_press(18'h00002);
    total++; if (aluop !== 4'd2) begin bad++; $display("[TB] FAIL clean_op: got %0d want 2", aluop); end
    total++; if (ov_total - ov0 != 1) begin
      bad++; $display("[TB] FAIL clean_opvalid: got %0d cycles want 1", ov_total - ov0);
    end
    total++; if (result !== 32'h00000003 || flags !== 3'b000 || state !== 3'd4) begin
      bad++; $display("[TB] FAIL clean_result: res=%h fl=%b state=%0d want 00000003/000/4", result, flags, state);
    end
  endtask

  task automatic test_held_key();
    logic [17:0] s;
    if (m_state != 0) do_press(18'h20000);
    s = rand_sw();
    @(negedge CLK);
    sw    = s;
    key_n = 1'b0;
    repeat (1000) @(negedge CLK);
    key_n = 1'b1;
    repeat (D + 6) @(negedge CLK);
    model_press(s);
    total++; if (state !== 3'(m_state) || portA !== m_a || portB !== m_b) begin
      bad++; $display("[TB] FAIL held_key: state=%0d A=%h B=%h want %0d/%h/%h", state, portA, portB, m_state, m_a, m_b);
    end
  endtask

  task automatic test_bounce();
    logic [17:0] s;
    s = rand_sw();
    @(negedge CLK);
    sw = s;
    for (int i = 0; i < 10; i++) begin
      key_n = i[0];
      repeat (2) @(negedge CLK);
    end
    key_n = 1'b0;
    repeat (10) @(negedge CLK);
    key_n = 1'b1;
    repeat (D + 6) @(negedge CLK);
    model_press(s);
    total++; if (state !== 3'(m_state) || portB !== m_b || portA !== m_a) begin
      bad++; $display("[TB] FAIL bounce: state=%0d A=%h B=%h want %0d/%h/%h", state, portA, portB, m_state, m_a, m_b);
    end
  endtask

  task automatic test_abort();
    logic [31:0] pa, pb, pr;
    goto_load_op();
    pa = m_a; pb = m_b; pr = m_res;
    do_press({1'b1, 17'($urandom)});
    total++; if (state !== 3'd0 || portA !== pa || portB !== pb || result !== pr) begin
      bad++; $display("[TB] FAIL abort: state=%0d A=%h B=%h res=%h want 0/%h/%h/%h", state, portA, portB, result, pa, pb, pr);
    end
  endtask

  task automatic test_random();
    logic [17:0] s;
    for (int i = 0; i < 16; i++) begin
      s = rand_sw();
      if ($urandom_range(0, 5) == 0) s[17] = 1'b1;
      do_press(s);
      total++; if (state !== 3'(m_state) || portA !== m_a || portB !== m_b || aluop !== m_op) begin
        bad++; $display("[TB] FAIL rand_regs[%0d]: st=%0d A=%h B=%h op=%h want %0d/%h/%h/%h",
                        i, state, portA, portB, aluop, m_state, m_a, m_b, m_op);
      end
      total++; if (result !== m_res || flags !== m_flags || op_valid !== 1'b0) begin
        bad++; $display("[TB] FAIL rand_result[%0d]: res=%h fl=%b v=%b want %h/%b/0",
                        i, result, flags, op_valid, m_res, m_flags);
      end
    end
  endtask

  task automatic test_press_in_exec();
    logic [17:0] s;
    bit seen;
    int ov0;
    goto_load_op();
    s = rand_sw();
    ov0 = ov_total;
    seen = 0;
    @(negedge CLK);
    sw    = s;
    key_n = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLK);
      if (op_valid === 1'b1) seen = 1;
    end
    total++; if (!seen) begin bad++; $display("[TB] FAIL exec_press_reach: got no EXEC want EXEC"); end
    sw[17] = 1'b1;
    force dut.press_q = 1'b1;
    #4;
    release dut.press_q;
    @(negedge CLK);
    model_press(s);
    total++; if (state !== 3'd4) begin bad++; $display("[TB] FAIL exec_press_state: got %0d want 4", state); end
    key_n = 1'b1;
    repeat (D + 6) @(negedge CLK);
    total++; if (result !== m_res || flags !== m_flags || state !== 3'd4 || ov_total - ov0 != 1) begin
      bad++; $display("[TB] FAIL exec_press_capture: res=%h fl=%b st=%0d execs=%0d want %h/%b/4/1",
                      result, flags, state, ov_total - ov0, m_res, m_flags);
    end
  endtask

  task automatic test_reset_exec();
    bit seen;
    goto_load_op();
    seen = 0;
    @(negedge CLK);
    sw    = rand_sw();
    key_n = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLK);
      if (op_valid === 1'b1) seen = 1;
    end
    total++; if (!seen) begin bad++; $display("[TB] FAIL rst_exec_reach: got no EXEC want EXEC"); end
    nRST  = 1'b0;
    key_n = 1'b1;
    model_reset();
    #1;
    total++; if ({portA, portB, aluop, result, flags, op_valid, state} !== '0) begin
      bad++; $display("[TB] FAIL rst_exec_async: A=%h B=%h op=%h res=%h fl=%h v=%b st=%0d want all 0",
                      portA, portB, aluop, result, flags, op_valid, state);
    end
    @(negedge CLK);
    nRST = 1'b1;
    repeat (2 * D + 8) @(negedge CLK);
    total++; if (state !== 3'd0 || result !== 32'd0 || flags !== 3'd0 || portA !== 32'd0) begin
      bad++; $display("[TB] FAIL rst_exec_after: st=%0d res=%h fl=%b A=%h want 0/0/0/0", state, result, flags, portA);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total    = 0;
    bad      = 0;
    ov_total = 0;
    test_reset();
    test_clean_sequence();
    test_held_key();
    test_bounce();
    test_abort();
    test_random();
    test_press_in_exec();
    test_reset_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
